neopixel_strip_controller: RTL and testbench
============================================

// Module: neopixel_strip_controller
// PURPOSE
//  Frame-level scheduler for a WS2812 strip: holds NUM_PIXELS 24-bit GRB words in a local frame buffer,
//  applies global brightness, and sequences pixels back-to-back into a bit encoder, followed by the
//  latch gap. Sits between the host register interface and the one_wire pad; frames are started manually or by auto-refresh.
// PARAMETERS
//  CLOCK_SPEED_HZ  32_000_000  system clock; all timing derived from it
//  NUM_PIXELS      8           pixels per frame (>=1)
//  ADDR_W          3           frame-buffer address width, 2**ADDR_W >= NUM_PIXELS
//  REFRESH_HZ      60          auto-refresh rate
// PORTS
//  clock         in   1       system clock
//  reset         in   1       synchronous, active-high
//  wr_en         in   1       frame-buffer write strobe
//  wr_addr       in   ADDR_W  pixel index
//  wr_color      in   24      GRB, bit 23 sent first
//  brightness    in   8       global scale, sampled at frame start
//  start         in   1       request one frame (level sampled each cycle)
//  auto_refresh  in   1       enable periodic frames at REFRESH_HZ
//  busy          out  1       high from frame start until frame_done
//  frame_done    out  1       one-cycle pulse after latch gap completes
//  one_wire      out  1       strip data line
// BEHAVIOUR
//  Reset: one_wire=0, busy=0, frame_done=0, state=IDLE, refresh counter=0, pending=0. Buffer not reset (contents undefined until written).
//  Timing (integer division): T0H=CLOCK_SPEED_HZ/3333333, T1H=CLOCK_SPEED_HZ/1111111, T_BIT=T0H+T1H,
//   T_LATCH=CLOCK_SPEED_HZ/12500. @32MHz: 9/28/37/2560 cycles. Bit '1': high T1H, low T0H; bit '0': high T0H, low T1H.
//  States: IDLE -> FETCH -> SEND -> LATCH -> IDLE.
//   IDLE: start or pending -> FETCH, pix_idx=0, brightness latched, busy=1.
//   FETCH: buffer read (1-cycle latency), scale, load word into encoder; one_wire first high 3 cycles after start sampled.
//   SEND: next pixel prefetched+scaled during current pixel; encoder accepts it on its enc_done cycle -> zero gap,
//    every bit exactly T_BIT cycles. After pixel NUM_PIXELS-1 enc_done -> LATCH.
//   LATCH: one_wire=0 for T_LATCH cycles, then frame_done=1 for one cycle, busy=0, -> IDLE.
//  Scaling per channel: c' = (c * (brightness+1)) >> 8, 16-bit intermediate; brightness=255 is identity, 0 -> 0x00.
//  Writes: accepted every cycle incl. while busy; addr >= NUM_PIXELS ignored. Pixel not yet fetched shows new value
//   in current frame; already fetched pixel keeps old value (tearing accepted).
//  start while busy: ignored, not queued.
//  Auto-refresh: free-running counter wraps at CLOCK_SPEED_HZ/REFRESH_HZ-1; on wrap with auto_refresh=1: IDLE -> frame start;
//   busy -> pending=1, frame starts the cycle after frame_done. Wrap + start same cycle -> one frame. Pending cleared when auto_refresh=0.
//  Reset mid-frame: one_wire=0 next edge, encoder aborted, no frame_done; strip recovers because next frame is preceded by idle low.
// STRUCTURE
//  neopixel_pkg: timing constants (T0H,T1H,T_BIT,T_LATCH) as functions of CLOCK_SPEED_HZ, state enum, GRB byte offsets.
//  Sub-module neopixel_bit_encoder: 24-bit shift register + bit timer; in: clock, reset, enc_load, enc_word[23:0];
//   out: one_wire, enc_ready, enc_done (pulse on final cycle of bit 0 low phase). Controller owns buffer, scaling, FSM, refresh timer, LATCH drive.
// TESTING
//  1 Reset held 5 cycles -> one_wire=0, busy=0, frame_done=0; no activity for 10k cycles with auto_refresh=0.
//  2 NUM_PIXELS=2, pix0=0xFF0000, pix1=0x000001, brightness=255, start -> 48 high pulses, period 37; pulses 0-7 and 47 high 28, rest high 9;
//    then 2560 low; frame_done pulse exactly once, busy falls same cycle.
//  3 pix0=0x808080, brightness=127 -> transmitted 0x404040; brightness=0 -> all pulses 9 cycles high.
//  4 start pulsed mid-frame -> ignored (only one frame_done); auto-refresh wrap mid-frame -> next frame starts cycle after frame_done.
//  5 reset asserted during a T1H high phase -> one_wire=0 next edge, busy=0; subsequent start yields a bit-exact frame.
//  6 write wr_addr=NUM_PIXELS -> buffer unchanged; write pix1 while pix0 still sending -> new pix1 value transmitted in same frame.

Source files
------------

// File: rtl/neopixel_pkg.sv
// Shared definitions for the WS2812 strip controller.
//  - Bit timing constants, derived from the system clock frequency by integer division.
//  - Frame scheduler state encoding.
//  - Byte offsets of the G, R and B channels inside a 24-bit GRB word.
package neopixel_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;

  localparam int G_OFS = 16;
  localparam int R_OFS = 8;
  localparam int B_OFS = 0;

  function automatic int t0h_cycles(input int clk_hz);
    return clk_hz / 3333333;
  endfunction

  function automatic int t1h_cycles(input int clk_hz);
    return clk_hz / 1111111;
  endfunction

  function automatic int tbit_cycles(input int clk_hz);
    return t0h_cycles(clk_hz) + t1h_cycles(clk_hz);
  endfunction

  function automatic int tlatch_cycles(input int clk_hz);
    return clk_hz / 12500;
  endfunction

endpackage

// File: rtl/neopixel_bit_encoder.sv
// WS2812 bit encoder: shifts out a 24-bit GRB word MSB first, one bit every T_BIT cycles.
// Bit '1' is high for T1H then low for T0H; bit '0' is high for T0H then low for T1H.
// Ports:
//  clock, reset      system clock, synchronous active-high reset (aborts any word in flight)
//  enc_load          load enc_word; honoured when idle or on the enc_done cycle (zero-gap chaining)
//  enc_word[23:0]    GRB word, bit 23 sent first
//  one_wire          encoded data line
//  enc_ready         idle, or currently sending the last bit of the word
//  enc_done          pulse on the final cycle of bit 0's low phase
module neopixel_bit_encoder
  import neopixel_pkg::*;
#(
  parameter int CLOCK_SPEED_HZ = 32_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enc_load,
  input  logic [23:0] enc_word,
  output logic        one_wire,
  output logic        enc_ready,
  output logic        enc_done
);

  localparam int T_BIT = tbit_cycles(CLOCK_SPEED_HZ);
  localparam int TMR_W = $clog2(T_BIT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(T_BIT - 1);
  localparam logic [TMR_W-1:0] HI_ONE   = TMR_W'(t1h_cycles(CLOCK_SPEED_HZ));
  localparam logic [TMR_W-1:0] HI_ZERO  = TMR_W'(t0h_cycles(CLOCK_SPEED_HZ));

  logic             active;
  logic [TMR_W-1:0] tmr;
  logic [4:0]       bit_cnt;
  logic [23:0]      shreg;
  logic             take;

  assign enc_done  = active && (tmr == TMR_LAST) && (bit_cnt == 5'd0);
  assign enc_ready = !active || (bit_cnt == 5'd0);
  assign take      = enc_load && (!active || enc_done);
  assign one_wire  = active && (tmr < (shreg[23] ? HI_ONE : HI_ZERO));

  always_ff @(posedge clock) begin
    if (reset) begin
      active  <= 1'b0;
      tmr     <= '0;
      bit_cnt <= '0;
    end else if (take) begin
      active  <= 1'b1;
      tmr     <= '0;
      bit_cnt <= 5'd23;
    end else if (active) begin
      if (tmr == TMR_LAST) begin
        tmr <= '0;
        if (bit_cnt == 5'd0) active <= 1'b0;
        else bit_cnt <= bit_cnt - 5'd1;
      end else begin
        tmr <= tmr + TMR_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (take) shreg <= enc_word;
    else if (active && (tmr == TMR_LAST)) shreg <= {shreg[22:0], 1'b0};
  end

endmodule

// File: rtl/neopixel_strip_controller.sv
// Frame-level scheduler for a WS2812 strip. Holds NUM_PIXELS GRB words, scales them by a
// brightness latched at frame start, streams them back-to-back through the bit encoder and
// finishes each frame with a low latch gap. Frames start on request or by auto-refresh.
// Ports:
//  clock, reset               system clock, synchronous active-high reset
//  wr_en, wr_addr, wr_color   frame-buffer write port (addresses >= NUM_PIXELS ignored)
//  brightness                 global scale, sampled when a frame starts
//  start                      frame request (ignored while busy)
//  auto_refresh               enable periodic frames at REFRESH_HZ
//  busy                       frame in progress
//  frame_done                 one-cycle pulse after the latch gap
//  one_wire                   strip data line
module neopixel_strip_controller
  import neopixel_pkg::*;
#(
  parameter int CLOCK_SPEED_HZ = 32_000_000,
  parameter int NUM_PIXELS     = 8,
  parameter int ADDR_W         = 3,
  parameter int REFRESH_HZ     = 60
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_color,
  input  logic [7:0]        brightness,
  input  logic              start,
  input  logic              auto_refresh,
  output logic              busy,
  output logic              frame_done,
  output logic              one_wire
);

  localparam int T_LATCH     = tlatch_cycles(CLOCK_SPEED_HZ);
  localparam int LAT_W       = $clog2(T_LATCH);
  localparam int REFRESH_DIV = CLOCK_SPEED_HZ / REFRESH_HZ;
  localparam int RC_W        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(T_LATCH - 1);
  localparam logic [RC_W-1:0]   RC_LAST  = RC_W'(REFRESH_DIV - 1);
  localparam logic [ADDR_W:0]   NPIX     = (ADDR_W + 1)'(NUM_PIXELS);

  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, b} + 16'd1);
    return 8'(prod >> 8);
  endfunction

  function automatic logic [23:0] scale_grb(input logic [23:0] w, input logic [7:0] b);
    return {scale_ch(w[G_OFS +: 8], b), scale_ch(w[R_OFS +: 8], b), scale_ch(w[B_OFS +: 8], b)};
  endfunction

  state_t            state, state_nxt;
  logic [23:0]       frame_buf [2**ADDR_W];
  logic [ADDR_W:0]   fetch_idx, load_cnt;
  logic [7:0]        bright_lat;
  logic [LAT_W-1:0]  lat_cnt;
  logic [RC_W-1:0]   rc;
  logic              pending;
  logic [23:0]       rd_word_p0, word_p1;
  logic              vld_p0, vld_p1;
  logic              enc_load, enc_ready, enc_done, enc_wire;
  logic              wrap, trigger, fetch_go;

  assign wrap     = (rc == RC_LAST);
  assign trigger  = start || pending || (wrap && auto_refresh);
  // Prefetch only once the encoder is on the last bit of its word, so late writes still show.
  assign fetch_go = ((state == FETCH) || (state == SEND)) && enc_ready && !vld_p0 && !vld_p1
                    && (fetch_idx < NPIX);
  assign enc_load = vld_p1 && ((state == FETCH) || ((state == SEND) && enc_done));
  assign busy     = (state != IDLE);
  assign one_wire = enc_wire && (state == SEND);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger) state_nxt = FETCH;
      FETCH:   if (enc_load) state_nxt = SEND;
      SEND:    if (enc_done && (load_cnt == NPIX)) state_nxt = LATCH;
      LATCH:   if (lat_cnt == LAT_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      fetch_idx  <= '0;
      load_cnt   <= '0;
      lat_cnt    <= '0;
      rc         <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= (state == LATCH) && (lat_cnt == LAT_LAST);
      rc         <= wrap ? '0 : rc + RC_W'(1);
      lat_cnt    <= (state == LATCH) ? lat_cnt + LAT_W'(1) : '0;
      // IDLE consumes a pending request as a frame start.
      if (!auto_refresh || (state == IDLE)) pending <= 1'b0;
      else if (wrap) pending <= 1'b1;
      if ((state == IDLE) && trigger) begin
        fetch_idx <= '0;
        load_cnt  <= '0;
      end else begin
        if (fetch_go) fetch_idx <= fetch_idx + (ADDR_W + 1)'(1);
        if (enc_load) load_cnt <= load_cnt + (ADDR_W + 1)'(1);
      end
      vld_p0 <= fetch_go;
      if (vld_p0) vld_p1 <= 1'b1;
      else if (enc_load) vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if ((state == IDLE) && trigger) bright_lat <= brightness;
    if (wr_en && ({1'b0, wr_addr} < NPIX)) frame_buf[wr_addr] <= wr_color;
    // p0: buffer read
    if (fetch_go) rd_word_p0 <= frame_buf[fetch_idx[ADDR_W-1:0]];
    // p1: brightness scaling, word waits here for the encoder
    if (vld_p0) word_p1 <= scale_grb(rd_word_p0, bright_lat);
  end

  neopixel_bit_encoder #(.CLOCK_SPEED_HZ(CLOCK_SPEED_HZ)) u_enc (
    .clock    (clock),
    .reset    (reset),
    .enc_load (enc_load),
    .enc_word (word_p1),
    .one_wire (enc_wire),
    .enc_ready(enc_ready),
    .enc_done (enc_done)
  );

endmodule

// File: tb/tb_neopixel_strip_controller.sv
// Scoreboard bench for neopixel_strip_controller: expected pulse high-times are queued when a
// frame is requested and checked pulse by pulse by a line monitor.
module tb_neopixel_strip_controller;

  localparam int NP      = 2;
  localparam int AW      = 2;
  localparam int T0H     = 9;
  localparam int T1H     = 28;
  localparam int T_BIT   = 37;
  localparam int T_LATCH = 2560;
  localparam int RDIV    = 6400;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [23:0]   wr_color = '0;
  logic [7:0]    brightness = 8'd255;
  logic          start = 1'b0;
  logic          auto_refresh = 1'b0;
  logic          busy, frame_done, one_wire;

  neopixel_strip_controller #(
    .CLOCK_SPEED_HZ(32_000_000), .NUM_PIXELS(NP), .ADDR_W(AW), .REFRESH_HZ(5000)
  ) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_color(wr_color),
    .brightness(brightness), .start(start), .auto_refresh(auto_refresh),
    .busy(busy), .frame_done(frame_done), .one_wire(one_wire)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  logic [23:0] model_buf [NP];
  int rc = 0;
  int fd_count = 0;
  int fd_exp = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sc(input int c, input int b);
    return (c * (b + 1)) / 256;
  endfunction

  task automatic push_pixel(input int idx, input int b);
    int w, sw;
    w  = int'(model_buf[idx]);
    sw = (sc((w >> 16) & 255, b) << 16) | (sc((w >> 8) & 255, b) << 8) | sc(w & 255, b);
    for (int i = 23; i >= 0; i--) exp_q.push_back(((sw >> i) & 1) != 0 ? T1H : T0H);
  endtask

  // Refresh period reference, used only to place frames relative to the wrap.
  always @(posedge clock) begin
    if (reset) rc <= 0;
    else rc <= (rc == RDIV - 1) ? 0 : rc + 1;
  end

  // Line monitor
  int hi = 0, lo = 0, npulse = 0, last_hi = 0;
  logic prev_ow = 1'b0, prev_busy = 1'b0;
  always @(posedge clock) begin
    #1;
    if (reset) begin
      exp_q.delete();
      hi = 0; lo = 0; npulse = 0; prev_ow = 1'b0; prev_busy = 1'b0;
    end else begin
      if (one_wire && !prev_ow) begin
        if (npulse > 0) chk("period", hi + lo, T_BIT);
        hi = 1; lo = 0; npulse++;
      end else if (one_wire) begin
        hi++;
      end else if (prev_ow) begin
        if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
        else chk("high_time", hi, exp_q.pop_front());
        last_hi = hi; lo = 1;
      end else begin
        lo++;
      end
      if (frame_done) begin
        fd_count++;
        chk("tail_low", lo, (T_BIT - last_hi) + T_LATCH + 1);
        chk("npulse", npulse, 24 * NP);
        chk("sb_empty", exp_q.size(), 0);
        chk("busy_fall", int'({prev_busy, busy}), 2);
        npulse = 0;
      end
      prev_ow = one_wire; prev_busy = busy;
    end
  end

  task automatic wr(input int a, input logic [23:0] c);
    @(negedge clock);
    wr_en = 1'b1; wr_addr = AW'(a); wr_color = c;
    if (a < NP) model_buf[a] = c;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  task automatic wait_first_high(input string tag);
    int lat = 0;
    while (!one_wire && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    chk(tag, lat, 3);
  endtask

  task automatic start_frame(input int npush);
    @(negedge clock);
    start = 1'b1;
    for (int p = 0; p < npush; p++) push_pixel(p, int'(brightness));
    @(negedge clock);
    start = 1'b0;
    chk("busy_rise", busy, 1);
    wait_first_high("first_high_lat");
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!frame_done && n < 8000) begin
      @(negedge clock);
      n++;
    end
    chk(tag, frame_done, 1);
    fd_exp++;
  endtask

  task automatic idle_watch(input string tag, input int cycles);
    int act = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (one_wire || busy || frame_done) act++;
    end
    chk(tag, act, 0);
  endtask

  initial begin
    int n;
    // Reset
    repeat (5) @(negedge clock);
    chk("rst_one_wire", one_wire, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    reset = 1'b0;
    idle_watch("idle_no_activity", 10000);

    // Basic frame, full brightness
    wr(0, 24'hFF0000);
    wr(1, 24'h000001);
    brightness = 8'd255;
    start_frame(NP);
    wait_done("done_basic");
    chk("fd_count_basic", fd_count, fd_exp);

    // Scaling; brightness change after start must not affect the frame
    wr(0, 24'h808080);
    brightness = 8'd127;
    start_frame(NP);
    brightness = 8'd255;
    wait_done("done_b127");
    brightness = 8'd0;
    start_frame(NP);
    wait_done("done_b0");
    brightness = 8'd255;

    // start while busy is ignored
    start_frame(NP);
    repeat (500) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done("done_start_ignored");
    idle_watch("start_not_queued", 5000);
    chk("fd_count_ignored", fd_count, fd_exp);

    // Auto-refresh wrap mid-frame -> next frame right after frame_done
    n = 0;
    while (rc != 3000 && n < 7000) begin
      @(negedge clock);
      n++;
    end
    start_frame(NP);
    repeat (100) @(negedge clock);
    auto_refresh = 1'b1;
    wait_done("done_auto_first");
    for (int p = 0; p < NP; p++) push_pixel(p, int'(brightness));
    @(negedge clock);
    chk("auto_restart_busy", busy, 1);
    auto_refresh = 1'b0;
    wait_first_high("auto_first_high_lat");
    wait_done("done_auto_second");
    idle_watch("auto_off_idle", 7000);
    chk("fd_count_auto", fd_count, fd_exp);

    // Reset during a T1H high phase (pix0 = 0x808080, first bit '1')
    start_frame(NP);
    repeat (5) @(negedge clock);
    chk("pre_reset_high", one_wire, 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("abort_one_wire", one_wire, 0);
    chk("abort_busy", busy, 0);
    chk("abort_frame_done", frame_done, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    idle_watch("abort_no_done", 100);
    chk("fd_count_abort", fd_count, fd_exp);
    start_frame(NP);
    wait_done("done_after_abort");

    // Out-of-range writes ignored; late write to pix1 shows in the current frame
    wr(2, 24'h123456);
    wr(3, 24'hABCDEF);
    start_frame(NP);
    wait_done("done_oob_write");
    start_frame(1);
    repeat (100) @(negedge clock);
    wr(1, 24'h00FF00);
    push_pixel(1, int'(brightness));
    wait_done("done_late_write");
    chk("fd_count_final", fd_count, fd_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
